// File: rtl/encdec_pkg.sv
// encdec_pkg: shared types and constants for the encoder/decoder frame sequencer
package encdec_pkg;
  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_e;
  localparam int K = 3;
  localparam int G0 = 7;
  localparam int G1 = 5;
  localparam int DATA_W_DEF = 16;
  localparam int DEC_LATENCY_DEF = 32;
endpackage

// File: rtl/encdec_frame_ctrl_sat_counter.sv
// sat_counter: increment-by-one counter that holds at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q;
  // count up on inc, stop at the top value
  always_ff @(posedge clk)
    cnt_q <= reset ? '0 : (inc_i && !(&cnt_q)) ? cnt_q + W'(1) : cnt_q;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/encdec_frame_ctrl.sv
// encdec_frame_ctrl: sends one word per frame through the codec and checks the decoded result
module encdec_frame_ctrl
  import encdec_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEC_LATENCY = DEC_LATENCY_DEF,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_word,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              codec_clr,
  output logic              enc_enb,
  output logic              enc_bit,
  input  logic              dec_bit,
  output logic [DATA_W-1:0] out_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              mismatch,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  err_cnt
);
  localparam int RW = $clog2(DEC_LATENCY + DATA_W);
  localparam logic [RW-1:0] LAST = RW'(DEC_LATENCY + DATA_W - 1);
  localparam logic [RW-1:0] CAP = RW'(DEC_LATENCY);

  state_e state_q, state_d;
  logic [RW-1:0] k_q, k_d;
  logic [DATA_W-1:0] tx_q, tx_d, sh_q, sh_d, rx_q, rx_d, out_word_q, out_word_d;
  logic mismatch_q, mismatch_d, out_valid_q, out_valid_d;
  logic enc_enb_q, enc_enb_d, enc_bit_q, enc_bit_d, codec_clr_q, codec_clr_d;
  logic in_hs, out_hs, last;

  // next-state logic; outputs are registered from the next state so they line up with it
  always_comb begin
    in_hs = in_valid && state_q == IDLE;
    out_hs = out_valid_q && out_ready;
    last = state_q == RUN && k_q == LAST;
    state_d = state_q == IDLE ? (in_valid ? CLEAR : IDLE) :
              state_q == CLEAR ? RUN :
              state_q == RUN ? (last ? DONE : RUN) :
              (out_ready ? IDLE : DONE);
    k_d = state_q == RUN ? k_q + RW'(1) : '0;
    tx_d = in_hs ? in_word : tx_q;
    sh_d = in_hs ? in_word : state_d == RUN ? sh_q << 1 : sh_q;
    enc_bit_d = state_d == RUN && sh_q[DATA_W-1];
    rx_d = (state_q == RUN && k_q >= CAP) ? {rx_q[DATA_W-2:0], dec_bit} : rx_q;
    out_word_d = last ? rx_d : out_word_q;
    mismatch_d = last ? rx_d != tx_q : mismatch_q;
    out_valid_d = state_d == DONE;
    enc_enb_d = state_d == RUN;
    codec_clr_d = state_d == CLEAR;
  end

  // state and output registers
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      k_q <= '0;
      tx_q <= '0;
      sh_q <= '0;
      rx_q <= '0;
      out_word_q <= '0;
      mismatch_q <= 1'b0;
      out_valid_q <= 1'b0;
      enc_enb_q <= 1'b0;
      enc_bit_q <= 1'b0;
      codec_clr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      tx_q <= tx_d;
      sh_q <= sh_d;
      rx_q <= rx_d;
      out_word_q <= out_word_d;
      mismatch_q <= mismatch_d;
      out_valid_q <= out_valid_d;
      enc_enb_q <= enc_enb_d;
      enc_bit_q <= enc_bit_d;
      codec_clr_q <= codec_clr_d;
    end

  sat_counter #(.W(CNT_W)) u_frame_cnt (.clk(clk), .reset(reset), .inc_i(out_hs), .cnt_o(frame_cnt));
  sat_counter #(.W(CNT_W)) u_err_cnt (.clk(clk), .reset(reset), .inc_i(out_hs && mismatch_q), .cnt_o(err_cnt));

  assign in_ready = state_q == IDLE;
  assign codec_clr = codec_clr_q;
  assign enc_enb = enc_enb_q;
  assign enc_bit = enc_bit_q;
  assign out_word = out_word_q;
  assign out_valid = out_valid_q;
  assign mismatch = mismatch_q;
endmodule
